// File: rtl/in_selector.sv
// Addressed single-bit input port: synchronizes and debounces external pins,
// keeps sticky rising-edge flags and returns one addressed bit per accepted read.
module in_selector #(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned ADDR_W          = 3,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  pins,
   input  logic              read,
   input  logic              CE,
   input  logic [ADDR_W-1:0] addr,
   input  logic              mode,
   output logic              data,
   output logic              valid,
   output logic [WIDTH-1:0]  edgeFlags,
   output logic              irq
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES == 0) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

   logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
   logic [WIDTH-1:0]  sync_out;
   logic [WIDTH-1:0]  level_q;
   logic [WIDTH-1:0]  level_d;
   logic [WIDTH-1:0]  rise;
   logic [WIDTH-1:0]  clr;
   logic              req_q;
   logic [ADDR_W-1:0] req_addr_q;
   logic              req_mode_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= pins;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign level_d = sync_out;
      end else begin : g_debounce
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

         logic [CNT_W-1:0] cnt_q [WIDTH];
         logic [CNT_W-1:0] cnt_d [WIDTH];

         // A change is accepted only after the new value has been seen on
         // DEBOUNCE_CYCLES consecutive edges; any return to level restarts the count.
         always_comb begin
            level_d = level_q;
            for (int unsigned i = 0; i < WIDTH; i++) begin
               cnt_d[i] = cnt_q[i] + 1'b1;
               if (sync_out[i] == level_q[i]) begin
                  cnt_d[i] = '0;
               end else if (cnt_q[i] == CNT_LAST) begin
                  level_d[i] = sync_out[i];
                  cnt_d[i]   = '0;
               end
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int unsigned i = 0; i < WIDTH; i++) begin
                  cnt_q[i] <= '0;
               end
            end else begin
               for (int unsigned i = 0; i < WIDTH; i++) begin
                  cnt_q[i] <= cnt_d[i];
               end
            end
         end
      end
   endgenerate

   assign rise = level_d & ~level_q;

   // The clear lands on the edge that returns the pre-clear flag; a
   // simultaneous rise is OR-ed in afterwards so it wins.
   always_comb begin
      clr = '0;
      if (req_q && req_mode_q) begin
         clr[req_addr_q] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level_q    <= '0;
         edgeFlags  <= '0;
         req_q      <= 1'b0;
         req_addr_q <= '0;
         req_mode_q <= 1'b0;
         data       <= 1'b0;
         valid      <= 1'b0;
      end else begin
         level_q   <= level_d;
         edgeFlags <= (edgeFlags & ~clr) | rise;
         req_q     <= read & CE;
         if (read && CE) begin
            req_addr_q <= addr;
            req_mode_q <= mode;
         end
         valid <= req_q;
         if (req_q) begin
            data <= req_mode_q ? edgeFlags[req_addr_q] : level_q[req_addr_q];
         end
      end
   end

   assign irq = |edgeFlags;

endmodule

// File: tb/tb_in_selector.sv
// Scoreboard bench for in_selector: expected read data is queued when a read
// is issued and compared when valid appears; flag state is tracked by a small model.
module tb_in_selector;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] pins;
   logic       read;
   logic       CE;
   logic [2:0] addr;
   logic       mode;
   logic       data;
   logic       valid;
   logic [7:0] edgeFlags;
   logic       irq;

   int total = 0;
   int bad   = 0;

   logic       exp_q[$];
   logic [7:0] model_level = '0;
   logic [7:0] model_flags = '0;

   in_selector #(
      .WIDTH(8),
      .ADDR_W(3),
      .SYNC_STAGES(2),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pins(pins),
      .read(read),
      .CE(CE),
      .addr(addr),
      .mode(mode),
      .data(data),
      .valid(valid),
      .edgeFlags(edgeFlags),
      .irq(irq)
   );

   always #5 clk = ~clk;

   // Drive a settled pin pattern long enough for the level to follow it.
   task automatic settle(input logic [7:0] p);
      model_flags = model_flags | (p & ~model_level);
      model_level = p;
      @(negedge clk);
      pins = p;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [7:0] ef;
      rst = 1'b1; pins = 8'hFF; read = 1'b0; CE = 1'b0; addr = '0; mode = 1'b0;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({data, valid, edgeFlags, irq} !== 11'b0) begin
         bad++;
         $display("FAIL reset_outputs: data=%b valid=%b edgeFlags=%h irq=%b, want all 0",
                  data, valid, edgeFlags, irq);
      end
      rst = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         ef = (c == 6) ? 8'hFF : 8'h00;
         total++;
         if (edgeFlags !== ef || irq !== (c == 6)) begin
            bad++;
            $display("FAIL reset_latency c%0d: edgeFlags=%h irq=%b, want %h %b",
                     c, edgeFlags, irq, ef, (c == 6));
         end
      end
      model_level = 8'hFF;
      model_flags = 8'hFF;
   endtask

   task automatic test_debounce();
      logic e;
      settle(8'hF7);
      @(negedge clk);
      read = 1'b1; CE = 1'b1; addr = 3'd3; mode = 1'b1;
      exp_q.push_back(model_flags[3]);
      model_flags[3] = 1'b0;
      @(negedge clk);
      read = 1'b0; CE = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (valid !== 1'b1 || data !== e) begin
         bad++;
         $display("FAIL clear3: valid=%b data=%b, want 1 %b", valid, data, e);
      end
      total++;
      if (edgeFlags !== model_flags) begin
         bad++;
         $display("FAIL clear3_flags: edgeFlags=%h, want %h", edgeFlags, model_flags);
      end

      // 3-cycle glitch must be rejected
      @(negedge clk);
      pins = 8'hFF;
      repeat (3) @(negedge clk);
      pins = 8'hF7;
      repeat (10) @(negedge clk);
      total++;
      if (edgeFlags !== model_flags) begin
         bad++;
         $display("FAIL glitch_flag: edgeFlags=%h, want %h", edgeFlags, model_flags);
      end
      read = 1'b1; CE = 1'b1; addr = 3'd3; mode = 1'b0;
      exp_q.push_back(1'b0);
      @(negedge clk);
      read = 1'b0; CE = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (valid !== 1'b1 || data !== e) begin
         bad++;
         $display("FAIL glitch_level: valid=%b data=%b, want 1 %b", valid, data, e);
      end

      // 4-cycle pulse is accepted exactly 6 cycles after the rise
      @(negedge clk);
      pins = 8'hFF;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 4) pins = 8'hF7;
         if (c == 5) begin
            total++;
            if (edgeFlags !== 8'hF7) begin
               bad++;
               $display("FAIL pulse_early: edgeFlags=%h, want f7", edgeFlags);
            end
         end
         if (c == 6) begin
            total++;
            if (edgeFlags !== 8'hFF) begin
               bad++;
               $display("FAIL pulse_flag: edgeFlags=%h, want ff", edgeFlags);
            end
            read = 1'b1; CE = 1'b1; addr = 3'd3; mode = 1'b0;
            exp_q.push_back(1'b1);
         end
         if (c == 7) begin
            read = 1'b0; CE = 1'b0;
         end
         if (c == 8) begin
            e = exp_q.pop_front();
            total++;
            if (valid !== 1'b1 || data !== e) begin
               bad++;
               $display("FAIL pulse_level: valid=%b data=%b, want 1 %b", valid, data, e);
            end
         end
      end
      model_flags[3] = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_level_read();
      logic [7:0] pat;
      logic       e;
      int         nvalid = 0;
      int         first  = -1;
      int         last   = -1;
      pat = 8'hA5;
      settle(pat);
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         if (valid === 1'b1) begin
            nvalid++;
            if (first < 0) first = cyc;
            last = cyc;
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               total++;
               if (data !== e) begin
                  bad++;
                  $display("FAIL level_read #%0d: data=%b, want %b", nvalid - 1, data, e);
               end
            end
         end
         if (cyc < 8) begin
            read = 1'b1; CE = 1'b1; addr = 3'(cyc); mode = 1'b0;
            exp_q.push_back(pat[cyc]);
         end else begin
            read = 1'b0; CE = 1'b0;
         end
      end
      total++;
      if (nvalid != 8 || last - first != 7 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL level_read_strobes: count=%0d span=%0d left=%0d, want 8 7 0",
                  nvalid, last - first, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_edge_clear();
      logic e;
      int   nvalid = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         if (valid === 1'b1) begin
            nvalid++;
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               total++;
               if (data !== e) begin
                  bad++;
                  $display("FAIL clear_all #%0d: data=%b, want %b", nvalid - 1, data, e);
               end
            end
         end
         if (cyc < 8) begin
            read = 1'b1; CE = 1'b1; addr = 3'(cyc); mode = 1'b1;
            exp_q.push_back(model_flags[cyc]);
            model_flags[cyc] = 1'b0;
         end else begin
            read = 1'b0; CE = 1'b0;
         end
      end
      total++;
      if (nvalid != 8 || edgeFlags !== 8'h00 || irq !== 1'b0) begin
         bad++;
         $display("FAIL clear_all_state: valids=%0d edgeFlags=%h irq=%b, want 8 00 0",
                  nvalid, edgeFlags, irq);
         exp_q.delete();
      end

      settle(8'h85);
      settle(8'hA5);
      total++;
      if (edgeFlags !== model_flags || irq !== 1'b1) begin
         bad++;
         $display("FAIL flag5_set: edgeFlags=%h irq=%b, want %h 1", edgeFlags, irq, model_flags);
      end
      read = 1'b1; CE = 1'b1; addr = 3'd5; mode = 1'b1;
      exp_q.push_back(model_flags[5]);
      model_flags[5] = 1'b0;
      @(negedge clk);
      read = 1'b0; CE = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (valid !== 1'b1 || data !== e || edgeFlags !== 8'h00 || irq !== 1'b0) begin
         bad++;
         $display("FAIL read_clear5: valid=%b data=%b edgeFlags=%h irq=%b, want 1 %b 00 0",
                  valid, data, edgeFlags, irq, e);
      end
      @(negedge clk);
      total++;
      if (valid !== 1'b0) begin
         bad++;
         $display("FAIL valid_one_cycle: valid=%b, want 0", valid);
      end
      read = 1'b1; CE = 1'b1; addr = 3'd5; mode = 1'b1;
      exp_q.push_back(model_flags[5]);
      @(negedge clk);
      read = 1'b0; CE = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (valid !== 1'b1 || data !== e) begin
         bad++;
         $display("FAIL repeat_read5: valid=%b data=%b, want 1 %b", valid, data, e);
      end
   endtask

   task automatic test_collision();
      logic e;
      settle(8'h85);
      settle(8'hA5);
      settle(8'h85);
      @(negedge clk);
      pins = 8'hA5;
      repeat (4) @(negedge clk);
      read = 1'b1; CE = 1'b1; addr = 3'd5; mode = 1'b1;
      exp_q.push_back(model_flags[5]);
      @(negedge clk);
      read = 1'b0; CE = 1'b0;
      @(negedge clk);
      model_level = 8'hA5;
      e = exp_q.pop_front();
      total++;
      if (valid !== 1'b1 || data !== e) begin
         bad++;
         $display("FAIL collision_data: valid=%b data=%b, want 1 %b", valid, data, e);
      end
      total++;
      if (edgeFlags !== 8'h20 || irq !== 1'b1) begin
         bad++;
         $display("FAIL collision_flag: edgeFlags=%h irq=%b, want 20 1", edgeFlags, irq);
      end

      // back-to-back clearing reads of the same bit
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(negedge clk);
         if (cyc >= 2) begin
            e = exp_q.pop_front();
            total++;
            if (valid !== 1'b1 || data !== e) begin
               bad++;
               $display("FAIL back_to_back #%0d: valid=%b data=%b, want 1 %b",
                        cyc - 2, valid, data, e);
            end
         end
         if (cyc < 2) begin
            read = 1'b1; CE = 1'b1; addr = 3'd5; mode = 1'b1;
            exp_q.push_back(model_flags[5]);
            model_flags[5] = 1'b0;
         end else begin
            read = 1'b0; CE = 1'b0;
         end
      end
   endtask

   task automatic test_gating_reset();
      settle(8'h85);
      settle(8'hA5);
      @(negedge clk);
      read = 1'b1; CE = 1'b0; addr = 3'd5; mode = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if (valid !== 1'b0) begin
            bad++;
            $display("FAIL gated_valid c%0d: valid=%b, want 0", c, valid);
         end
      end
      read = 1'b0;
      @(negedge clk);
      total++;
      if (edgeFlags !== model_flags) begin
         bad++;
         $display("FAIL gated_flags: edgeFlags=%h, want %h", edgeFlags, model_flags);
      end

      read = 1'b1; CE = 1'b1; addr = 3'd5; mode = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0; read = 1'b0; CE = 1'b0; pins = 8'h00;
      #1;
      total++;
      if ({data, valid, edgeFlags, irq} !== 11'b0) begin
         bad++;
         $display("FAIL async_reset: data=%b valid=%b edgeFlags=%h irq=%b, want all 0",
                  data, valid, edgeFlags, irq);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_level = '0;
      model_flags = '0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         total++;
         if (valid !== 1'b0 || data !== 1'b0 || edgeFlags !== 8'h00) begin
            bad++;
            $display("FAIL discarded_read c%0d: valid=%b data=%b edgeFlags=%h, want 0 0 00",
                     c, valid, data, edgeFlags);
         end
      end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_level_read();
      test_edge_clear();
      test_collision();
      test_gating_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
